cp0_reg: RTL
============

Name: cp0_reg

Overview:
- Coprocessor-0 register file at the write-back end of the pipeline.
- Consumes the WB-stage CP0 write triple (we/addr/data) and commits it. Serves MFC0 reads to EX with same-cycle write bypass.
- Keeps the free-running Count/Compare timer.
- Takes exception/ERET commit events from the MEM-stage exception logic and updates Status, Cause, EPC and BadVAddr.

Parameters:
- PRID_VAL, 32'h0000_4220, read-only value of PRId (reg 15).
- CONFIG_VAL, 32'h0000_0000, read-only value of Config (reg 16).
- STATUS_RST, 32'h1000_0000, Status reset value (CU0=1, EXL=0, IE=0).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-low (0 = reset).
- we  in  1  CP0 write enable from WB.
- waddr  in  5  CP0 write register number.
- wdata  in  32  CP0 write data.
- raddr  in  5  CP0 read register number.
- rdata  out  32  read data, combinational.
- int_i  in  6  hardware interrupt lines.
- exc_valid  in  1  exception commit pulse.
- exc_code  in  5  ExcCode for Cause[6:2].
- exc_pc  in  32  PC of the faulting instruction.
- exc_in_delay  in  1  faulting instruction is in a delay slot.
- exc_badvaddr  in  32  faulting address.
- exc_badv_we  in  1  load BadVAddr on this exception.
- eret  in  1  ERET commit pulse.
- count_o  out  32  Count register.
- compare_o  out  32  Compare register.
- status_o  out  32  Status register.
- cause_o  out  32  Cause register.
- epc_o  out  32  EPC register.
- badvaddr_o  out  32  BadVAddr register.
- timer_int_o  out  1  timer interrupt pending.

Behaviour:
- Implemented registers: BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13), EPC(14), PRId(15), Config(16). Any other address reads 0; writes to it are ignored.
- Reset (rst=0 at posedge):
  - Count, Compare, Cause, EPC, BadVAddr = 0.
  - Status = STATUS_RST.
  - timer_int_o = 0.
  - Reset wins over every other input in that cycle.
- Count:
  - Increments by 1 every cycle; 32'hFFFF_FFFF wraps to 0.
  - A software write to Count loads wdata and suppresses that cycle's increment.
- Status write mask: only bits 28, 15:8, 1, 0 are updated; all others hold.
- Cause:
  - Software-writable bits are IP[1:0] (bits 9:8) only.
  - IP[7:2] (bits 15:10) are reloaded from the interrupt sources every cycle.
  - Bits 31 (BD) and 6:2 (ExcCode) change only on exception.
  - All other Cause bits read 0.
- EPC, BadVAddr, Compare: full 32-bit software-writable. PRId and Config are read-only.
- Exception (exc_valid=1):
  - Cause[6:2] = exc_code and Status.EXL = 1.
  - If Status.EXL was 0 before the edge: EPC = exc_pc − 4 and Cause.BD = 1 when exc_in_delay, otherwise EPC = exc_pc and BD = 0.
  - If EXL was already 1: EPC and BD hold.
  - BadVAddr = exc_badvaddr when exc_badv_we=1.
- ERET (eret=1, exc_valid=0): Status.EXL = 0. Nothing else changes.
- Simultaneous events:
  - exc_valid has priority over eret.
  - When exc_valid or eret is 1, the software write is discarded, because the writing instruction is flushed.
  - Count increment still occurs in that cycle.
- Read bypass: if we=1, waddr==raddr and the register is writable, rdata returns the post-mask value that will be committed. Otherwise rdata returns the current register value.
- Outputs count_o through badvaddr_o show register state. They update one cycle after the write or event.

Optional Feature:
- Macro: CP0_TIMER_INT_EN.
- Defined:
  - timer_int_o sets on the cycle after Count == Compare with Compare ≠ 0.
  - It stays set until a software write to Compare clears it. The clear wins over a simultaneous match.
  - Cause.IP7 reflects timer_int_o, and Cause.IP[6:2] = int_i[4:0].
- Not defined:
  - timer_int_o is tied to 0 and no match logic is built.
  - Cause.IP[7:2] = int_i[5:0].

Test Plan:
- Release reset, idle 10 cycles → count_o = 10, status_o = 32'h1000_0000, cause_o = 0. Write Count = 32'hFFFF_FFFE → count_o goes 32'hFFFF_FFFE, FFFF_FFFF, 0.
- Write Status = 32'hFFFF_FFFF → status_o = 32'h1000_FF03. In the same cycle, raddr = 12 reads rdata = 32'h1000_FF03 (bypass).
- exc_valid with exc_code = 5'h04, exc_pc = 32'h8000_0104, exc_in_delay = 1, badv = 32'h0000_0003, exc_badv_we = 1 → epc_o = 32'h8000_0100, cause_o[31] = 1, cause_o[6:2] = 4, badvaddr_o = 3, EXL = 1. A second exception with exc_pc = 32'h8000_0200 → EPC unchanged.
- eret → EXL = 0. exc_valid and eret together with we to EPC = 32'h1234 → exception applied, EPC write discarded.
- CP0_TIMER_INT_EN defined: write Compare = 20 with Count at 10 → timer_int_o = 1 eleven cycles later and cause_o[15] = 1. Write Compare = 100 → timer_int_o = 0 next cycle.
- Assert rst = 0 mid-exception, with exc_valid high → all registers return to reset values and the exception is not recorded.

Source files
------------

// File: rtl/cp0_reg.sv
// Coprocessor-0 register file: software read/write, Count/Compare timer, exception/ERET commit.
// Optional build macro CP0_TIMER_INT_EN adds the Count==Compare timer interrupt on Cause.IP7.
module cp0_reg #(
  parameter logic [31:0] PRID_VAL   = 32'h0000_4220,
  parameter logic [31:0] CONFIG_VAL = 32'h0000_0000,
  parameter logic [31:0] STATUS_RST = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr,
  output logic [31:0] rdata,
  input  logic [5:0]  int_i,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        exc_in_delay,
  input  logic [31:0] exc_badvaddr,
  input  logic        exc_badv_we,
  input  logic        eret,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] badvaddr_o,
  output logic        timer_int_o
);

  localparam logic [4:0]  A_BADV    = 5'd8;
  localparam logic [4:0]  A_COUNT   = 5'd9;
  localparam logic [4:0]  A_COMPARE = 5'd11;
  localparam logic [4:0]  A_STATUS  = 5'd12;
  localparam logic [4:0]  A_CAUSE   = 5'd13;
  localparam logic [4:0]  A_EPC     = 5'd14;
  localparam logic [4:0]  A_PRID    = 5'd15;
  localparam logic [4:0]  A_CONFIG  = 5'd16;
  localparam logic [31:0] STATUS_WMASK = 32'h1000_FF03;

  function automatic logic [31:0] status_merge(input logic [31:0] cur, input logic [31:0] wd);
    return (cur & ~STATUS_WMASK) | (wd & STATUS_WMASK);
  endfunction

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic [31:0] status_q, status_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badv_q, badv_d;
  logic        bd_q, bd_d;
  logic [4:0]  excode_q, excode_d;
  logic [1:0]  ipsw_q, ipsw_d;
  logic        timer_q, timer_d;
  logic [5:0]  iphw_view;
  logic [31:0] cause_view;
  logic        wr_en;

`ifdef CP0_TIMER_INT_EN
  logic [4:0] iphw_q, iphw_d;
  assign iphw_d    = int_i[4:0];
  assign iphw_view = {timer_q, iphw_q};
`else
  logic [5:0] iphw_q, iphw_d;
  assign iphw_d    = int_i;
  assign iphw_view = iphw_q;
`endif

  // A flushed instruction never commits its CP0 write.
  assign wr_en      = we & ~exc_valid & ~eret;
  assign cause_view = {bd_q, 15'b0, iphw_view, ipsw_q, 1'b0, excode_q, 2'b00};

  always_comb begin
    count_d   = count_q + 32'd1;
    compare_d = compare_q;
    status_d  = status_q;
    epc_d     = epc_q;
    badv_d    = badv_q;
    bd_d      = bd_q;
    excode_d  = excode_q;
    ipsw_d    = ipsw_q;
    timer_d   = 1'b0;
    if (wr_en) begin
      case (waddr)
        A_COUNT:   count_d   = wdata;
        A_COMPARE: compare_d = wdata;
        A_STATUS:  status_d  = status_merge(status_q, wdata);
        A_CAUSE:   ipsw_d    = wdata[9:8];
        A_EPC:     epc_d     = wdata;
        A_BADV:    badv_d    = wdata;
        default:   ;
      endcase
    end
    if (exc_valid) begin
      excode_d    = exc_code;
      status_d[1] = 1'b1;
      // Nested exceptions keep the original return point.
      if (!status_q[1]) begin
        epc_d = exc_in_delay ? exc_pc - 32'd4 : exc_pc;
        bd_d  = exc_in_delay;
      end
      if (exc_badv_we) badv_d = exc_badvaddr;
    end else if (eret) begin
      status_d[1] = 1'b0;
    end
`ifdef CP0_TIMER_INT_EN
    timer_d = timer_q;
    if (count_q == compare_q && compare_q != 32'd0) timer_d = 1'b1;
    if (wr_en && waddr == A_COMPARE) timer_d = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q   <= 32'd0;
      compare_q <= 32'd0;
      status_q  <= STATUS_RST;
      epc_q     <= 32'd0;
      badv_q    <= 32'd0;
      bd_q      <= 1'b0;
      excode_q  <= 5'd0;
      ipsw_q    <= 2'd0;
      iphw_q    <= '0;
      timer_q   <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      status_q  <= status_d;
      epc_q     <= epc_d;
      badv_q    <= badv_d;
      bd_q      <= bd_d;
      excode_q  <= excode_d;
      ipsw_q    <= ipsw_d;
      iphw_q    <= iphw_d;
      timer_q   <= timer_d;
    end
  end

  always_comb begin
    case (raddr)
      A_BADV:    rdata = badv_q;
      A_COUNT:   rdata = count_q;
      A_COMPARE: rdata = compare_q;
      A_STATUS:  rdata = status_q;
      A_CAUSE:   rdata = cause_view;
      A_EPC:     rdata = epc_q;
      A_PRID:    rdata = PRID_VAL;
      A_CONFIG:  rdata = CONFIG_VAL;
      default:   rdata = 32'd0;
    endcase
    // Same-cycle bypass of the value this write will commit.
    if (we && waddr == raddr) begin
      case (raddr)
        A_BADV, A_COUNT, A_COMPARE, A_EPC: rdata = wdata;
        A_STATUS: rdata = status_merge(status_q, wdata);
        A_CAUSE:  rdata = {cause_view[31:10], wdata[9:8], cause_view[7:0]};
        default:  ;
      endcase
    end
  end

  assign count_o     = count_q;
  assign compare_o   = compare_q;
  assign status_o    = status_q;
  assign cause_o     = cause_view;
  assign epc_o       = epc_q;
  assign badvaddr_o  = badv_q;
  assign timer_int_o = timer_q;

endmodule
